// File: rtl/register_file_rst_if.sv
// Bus bundle for register_file_rst: one write port, two read ports and the
// registered result flags. The master drives requests and the slave (the
// register bank) returns read data and flags.
interface register_file_rst_if #(
   parameter int WIDTH = 8,
   parameter int AW    = 3
);
   logic             wr_en;
   logic [1:0]       wr_op;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             rd_en_a;
   logic [AW-1:0]    rd_addr_a;
   logic [WIDTH-1:0] rd_data_a;
   logic             rd_en_b;
   logic [AW-1:0]    rd_addr_b;
   logic [WIDTH-1:0] rd_data_b;
   logic             flag_zero;
   logic             flag_carry;

   modport master (
      output wr_en, wr_op, wr_addr, wr_data,
      output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
      input  rd_data_a, rd_data_b, flag_zero, flag_carry
   );

   modport slave (
      input  wr_en, wr_op, wr_addr, wr_data,
      input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
      output rd_data_a, rd_data_b, flag_zero, flag_carry
   );
endinterface

// File: rtl/register_file_rst.sv
// General-purpose register bank: NREGS x WIDTH registers, one write port
// running LOAD/INC/DEC/CLR with registered zero/carry flags, and two
// independent combinational read ports that return 0 when disabled.
// Asynchronous active-high reset clears every register and both flags.
module register_file_rst #(
   parameter int WIDTH    = 8,
   parameter int NREGS    = 8,
   parameter int ZERO_REG = 0
) (
   input logic                clk,
   input logic                reset,
   register_file_rst_if.slave bus
);
   localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
   // With a hard-wired zero register, entry 0 is never written or read back.
   localparam int unsigned FIRST = (ZERO_REG != 0) ? 1 : 0;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_INC  = 2'b01,
      OP_DEC  = 2'b10,
      OP_CLR  = 2'b11
   } op_t;

   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH-1:0] old_val;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             wr_valid;
   logic             flag_zero_q;
   logic             flag_carry_q;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;

   // Decode write target: only writable addresses match, so out-of-range or
   // hard-wired-zero targets leave wr_valid low and the write is dropped.
   always_comb begin
      old_val  = '0;
      wr_valid = 1'b0;
      for (int unsigned i = FIRST; i < NREGS; i++) begin
         if (bus.wr_addr == AW'(i)) begin
            old_val  = regs[i];
            wr_valid = bus.wr_en;
         end
      end
   end

   // Compute the write result and its carry/borrow from the current value.
   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op_t'(bus.wr_op))
         OP_LOAD: result = bus.wr_data;
         OP_INC: begin
            result = old_val + WIDTH'(1);
            carry  = (old_val == '1);
         end
         OP_DEC: begin
            result = old_val - WIDTH'(1);
            carry  = (old_val == '0);
         end
         default: result = '0;
      endcase
   end

   // Register bank and flags; flags only change on an accepted write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
         flag_zero_q  <= 1'b0;
         flag_carry_q <= 1'b0;
      end else if (wr_valid) begin
         for (int unsigned i = FIRST; i < NREGS; i++) begin
            if (bus.wr_addr == AW'(i)) regs[i] <= result;
         end
         flag_zero_q  <= (result == '0);
         flag_carry_q <= carry;
      end
   end

   // Combinational read ports without write bypass; unmatched addresses read 0.
   always_comb begin
      rd_a = '0;
      rd_b = '0;
      for (int unsigned i = FIRST; i < NREGS; i++) begin
         if (bus.rd_en_a && bus.rd_addr_a == AW'(i)) rd_a = regs[i];
         if (bus.rd_en_b && bus.rd_addr_b == AW'(i)) rd_b = regs[i];
      end
   end

   assign bus.rd_data_a  = rd_a;
   assign bus.rd_data_b  = rd_b;
   assign bus.flag_zero  = flag_zero_q;
   assign bus.flag_carry = flag_carry_q;
endmodule

// File: tb/tb_register_file_rst.sv
// Scoreboard bench for register_file_rst. Two instances share stimulus:
// dut0 (NREGS=8, ZERO_REG=0) and dut1 (NREGS=6, ZERO_REG=1). A reference
// model of register contents and flags predicts each cycle's outputs; the
// driver queues predictions and a monitor compares them at the falling edge.
module tb_register_file_rst;
   localparam int W   = 8;
   localparam int MOD = 1 << W;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   register_file_rst_if #(.WIDTH(W), .AW(3)) if0 ();
   register_file_rst_if #(.WIDTH(W), .AW(3)) if1 ();

   register_file_rst #(.WIDTH(W), .NREGS(8), .ZERO_REG(0)) dut0 (
      .clk(clk), .reset(reset), .bus(if0.slave)
   );
   register_file_rst #(.WIDTH(W), .NREGS(6), .ZERO_REG(1)) dut1 (
      .clk(clk), .reset(reset), .bus(if1.slave)
   );

   typedef struct {
      int a0; int b0; int z0; int c0;
      int a1; int b1; int z1; int c1;
      string tag;
   } exp_t;

   exp_t sb[$];
   int tests = 0;
   int fails = 0;

   // reference state: register contents and flags per instance
   int m  [2][8];
   int fz [2];
   int fc [2];
   int nr [2] = '{8, 6};
   int zr [2] = '{0, 1};

   function automatic void check(string name, int d, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s dut%0d actual=0x%0h expected=0x%0h", name, d, act, exp);
      end
   endfunction

   function automatic int model_rd(int d, bit en, int a);
      if (!en || a >= nr[d] || (zr[d] != 0 && a == 0)) return 0;
      return m[d][a];
   endfunction

   function automatic void model_wr(int d, bit we, int op, int a, int data);
      int v, r, c;
      if (!we || a >= nr[d] || (zr[d] != 0 && a == 0)) return;
      v = m[d][a];
      case (op)
         0: begin r = data;              c = 0;          end
         1: begin r = (v + 1) % MOD;     c = (v == MOD - 1); end
         2: begin r = (v + MOD - 1) % MOD; c = (v == 0);   end
         default: begin r = 0;           c = 0;          end
      endcase
      m[d][a] = r;
      fz[d]   = (r == 0);
      fc[d]   = c;
   endfunction

   function automatic void model_clear();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 8; i++) m[d][i] = 0;
         fz[d] = 0;
         fc[d] = 0;
      end
   endfunction

   task automatic drive(bit we, int op, int a, int data, bit ea, int aa, bit eb, int ab);
      if0.wr_en = we;  if0.wr_op = 2'(op); if0.wr_addr = 3'(a); if0.wr_data = 8'(data);
      if0.rd_en_a = ea; if0.rd_addr_a = 3'(aa); if0.rd_en_b = eb; if0.rd_addr_b = 3'(ab);
      if1.wr_en = we;  if1.wr_op = 2'(op); if1.wr_addr = 3'(a); if1.wr_data = 8'(data);
      if1.rd_en_a = ea; if1.rd_addr_a = 3'(aa); if1.rd_en_b = eb; if1.rd_addr_b = 3'(ab);
   endtask

   // one clock cycle: drive just after the edge, predict pre-edge outputs, then advance model
   task automatic cycle(string tag, bit we, int op, int a, int data, bit ea, int aa, bit eb, int ab);
      exp_t e;
      @(posedge clk);
      #1;
      drive(we, op, a, data, ea, aa, eb, ab);
      e.a0 = model_rd(0, ea, aa); e.b0 = model_rd(0, eb, ab); e.z0 = fz[0]; e.c0 = fc[0];
      e.a1 = model_rd(1, ea, aa); e.b1 = model_rd(1, eb, ab); e.z1 = fz[1]; e.c1 = fc[1];
      e.tag = tag;
      sb.push_back(e);
      model_wr(0, we, op, a, data);
      model_wr(1, we, op, a, data);
   endtask

   // monitor: outputs are presented every cycle; compare whenever a prediction is pending
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".rd_a"}, 0, int'(if0.rd_data_a), e.a0);
            check({e.tag, ".rd_b"}, 0, int'(if0.rd_data_b), e.b0);
            check({e.tag, ".z"},    0, int'(if0.flag_zero), e.z0);
            check({e.tag, ".c"},    0, int'(if0.flag_carry), e.c0);
            check({e.tag, ".rd_a"}, 1, int'(if1.rd_data_a), e.a1);
            check({e.tag, ".rd_b"}, 1, int'(if1.rd_data_b), e.b1);
            check({e.tag, ".z"},    1, int'(if1.flag_zero), e.z1);
            check({e.tag, ".c"},    1, int'(if1.flag_carry), e.c1);
         end
      end
   end

   task automatic check_all_zero(string tag);
      check({tag, ".rd_a"}, 0, int'(if0.rd_data_a), 0);
      check({tag, ".rd_b"}, 0, int'(if0.rd_data_b), 0);
      check({tag, ".z"},    0, int'(if0.flag_zero), 0);
      check({tag, ".c"},    0, int'(if0.flag_carry), 0);
      check({tag, ".rd_a"}, 1, int'(if1.rd_data_a), 0);
      check({tag, ".z"},    1, int'(if1.flag_zero), 0);
      check({tag, ".c"},    1, int'(if1.flag_carry), 0);
   endtask

   initial begin
      int op, addr, data;
      model_clear();
      drive(0, 0, 0, 0, 1, 1, 1, 3);
      #2;
      check_all_zero("reset_state");
      #10;
      reset = 1'b0;

      // LOAD r3, read r3/r5, then disable port A
      cycle("t1_load",   1, 0, 3, 8'hA5, 0, 0, 0, 0);
      cycle("t1_read",   0, 0, 0, 0,     1, 3, 1, 5);
      cycle("t1_dis",    0, 0, 0, 0,     0, 3, 1, 3);
      // INC wrap and DEC borrow on r1
      cycle("t2_load",   1, 0, 1, 8'hFE, 1, 1, 0, 0);
      cycle("t2_inc1",   1, 1, 1, 0,     1, 1, 0, 0);
      cycle("t2_inc2",   1, 1, 1, 0,     1, 1, 0, 0);
      cycle("t2_dec",    1, 2, 1, 0,     1, 1, 1, 1);
      cycle("t2_read",   0, 0, 0, 0,     1, 1, 1, 1);
      // read-during-write returns the old value
      cycle("t3_rdw",    1, 0, 2, 8'h3C, 1, 2, 1, 2);
      cycle("t3_after",  0, 0, 0, 0,     1, 2, 1, 2);
      // zero register and out-of-range targets
      cycle("t5_r0",     1, 0, 0, 8'h55, 1, 0, 1, 0);
      cycle("t5_r0rd",   0, 0, 0, 0,     1, 0, 1, 0);
      cycle("t5_a7",     1, 0, 7, 8'h77, 1, 7, 1, 6);
      cycle("t5_a7rd",   1, 1, 6, 0,     1, 7, 1, 6);
      cycle("t5_a6rd",   0, 0, 0, 0,     1, 7, 1, 6);
      // CLR then idle: flags hold
      cycle("t6_load",   1, 0, 4, 8'h80, 1, 4, 0, 0);
      cycle("t6_clr",    1, 3, 4, 0,     1, 4, 0, 0);
      for (int i = 0; i < 3; i++) cycle("t6_hold", 0, 1, 4, 0, 1, 4, 1, 1);

      // asynchronous reset between edges, held across an edge with a write pending
      @(posedge clk);
      #1;
      drive(1, 0, 1, 8'h5A, 1, 1, 1, 2);
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("t4_async");
      @(posedge clk);
      #1;
      check_all_zero("t4_held");
      model_clear();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      reset = 1'b0;
      cycle("t4_post",   0, 0, 0, 0,     1, 1, 1, 2);

      // randomized traffic with edge-value bias for carry/zero
      for (int i = 0; i < 400; i++) begin
         op   = int'($urandom_range(0, 3));
         addr = int'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: data = 8'hFF;
            1: data = 0;
            default: data = int'($urandom_range(0, 255));
         endcase
         cycle("rand", ($urandom_range(0, 3) != 0), op, addr, data,
               $urandom_range(0, 4) != 0, int'($urandom_range(0, 7)),
               $urandom_range(0, 4) != 0, int'($urandom_range(0, 7)));
      end

      @(negedge clk);
      #1;
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL sb_drain actual=%0d expected=0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
